// File: rtl/aes_pkg.sv
// Shared AES definitions for the InvMixColumns sequencer.
//   - seq_state_e : sequencer states (IDLE / RUN / DONE), 2-bit encoding
//   - AES_STATE_W, AES_COL_W, AES_NCOL : state, column and column-count sizes
//   - aes_col_get : extract column c of a state; column 0 occupies the MSBs
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_COL_W   = 32;
  localparam int AES_NCOL    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Column c lives at bits [127-32c -: 32], row 0 in the column's top byte.
  function automatic logic [AES_COL_W-1:0] aes_col_get(input logic [AES_STATE_W-1:0] s,
                                                       input logic [1:0]             c);
    return s[AES_STATE_W-1-AES_COL_W*int'(c) -: AES_COL_W];
  endfunction

endpackage

// File: rtl/inv_mixcolum.sv
// Combinational InvMixColumns for one 32-bit AES column.
//   in  : input column, row 0 in bits [31:24]
//   out : column multiplied by the inverse MixColumns matrix
//         rows {0e 0b 0d 09} rotated right by one per output row
module inv_mixcolum (
  input  logic [31:0] in,
  output logic [31:0] out
);

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Products by 09/0b/0d/0e assembled from doublings.
  function automatic logic [31:0] mul_set(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    // packed as {09, 0b, 0d, 0e}
    return {x8 ^ a, x8 ^ x2 ^ a, x8 ^ x4 ^ a, x8 ^ x4 ^ x2};
  endfunction

  logic [7:0]  a0, a1, a2, a3;
  logic [31:0] m0, m1, m2, m3;

  assign {a0, a1, a2, a3} = in;
  assign m0 = mul_set(a0);
  assign m1 = mul_set(a1);
  assign m2 = mul_set(a2);
  assign m3 = mul_set(a3);

  // m[31:24]=09, m[23:16]=0b, m[15:8]=0d, m[7:0]=0e
  assign out[31:24] = m0[7:0]   ^ m1[23:16] ^ m2[15:8]  ^ m3[31:24];
  assign out[23:16] = m0[31:24] ^ m1[7:0]   ^ m2[23:16] ^ m3[15:8];
  assign out[15:8]  = m0[15:8]  ^ m1[31:24] ^ m2[7:0]   ^ m3[23:16];
  assign out[7:0]   = m0[23:16] ^ m1[15:8]  ^ m2[31:24] ^ m3[7:0];

endmodule

// File: rtl/inv_mixcol_seq.sv
// AES-128 InvMixColumns sequencer: accepts a 128-bit state, runs its four
// columns through one shared inv_mixcolum instance (one column per clock,
// written back in place), then offers the result downstream.
//   clk, rst (async, active-high)
//   in_valid / in_ready / in_state / in_bypass : input handshake; bypass skips
//                                                the column pass (final round)
//   out_valid / out_ready / out_state          : result handshake
//   busy                                       : high while RUN or DONE
module inv_mixcol_seq
  import aes_pkg::*;
#(
  parameter int NCOL = AES_NCOL
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  input  logic                   in_bypass,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic                   busy
);

  localparam logic [1:0] LAST_COL = 2'(NCOL - 1);

  seq_state_e             state_q, state_d;
  logic [1:0]             col_q, col_d;
  logic [AES_STATE_W-1:0] work_q, work_d;
  logic [NCOL-1:0]        wen;
  logic [AES_COL_W-1:0]   col_sel, col_res;

  assign col_sel = aes_col_get(work_q, col_q);

  inv_mixcolum u_col (
    .in  (col_sel),
    .out (col_res)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    work_d  = work_q;
    wen     = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_state;
          col_d   = 2'd0;
          state_d = in_bypass ? DONE : RUN;
        end
      end
      RUN: begin
        wen[col_q] = 1'b1;
        col_d      = col_q + 2'd1;
        if (col_q == LAST_COL) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // In-place write-back; columns not yet visited still hold the input.
    for (int c = 0; c < NCOL; c++) begin
      if (wen[c]) work_d[AES_STATE_W-1-AES_COL_W*c -: AES_COL_W] = col_res;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      work_q  <= work_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_state = work_q;

endmodule

// File: tb/tb_inv_mixcol_seq.sv
module tb_inv_mixcol_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  inv_mixcol_seq #(.NCOL(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_bypass (in_bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  typedef struct {
    logic [127:0] st;
    logic         byp;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl[7];

  // ---------------- reference model: plain GF(2^8) arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [7:0]   coef[4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [7:0]   a[4];
    logic [7:0]   b;
    logic [127:0] r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127-32*c-8*k -: 8];
      for (int row = 0; row < 4; row++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++) b = b ^ gmul(coef[(k - row + 4) % 4], a[k]);
        r[127-32*c-8*row -: 8] = b;
      end
    end
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] garbage();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One complete transaction: accept, wait for result, drain (optionally with stalls).
  // Latency counts edges after the accepting edge: a normal state finishes on the
  // fourth, a bypassed one is presented in the cycle right after acceptance.
  task automatic xfer(input logic [127:0] s, input logic byp, input logic [127:0] exp,
                      input bit stall, input string tag);
    int n;
    bit moved;
    bit stable;
    chk({tag, " in_ready before"}, 128'(in_ready), 128'(1));
    in_valid  = 1'b1;
    in_state  = s;
    in_bypass = byp;
    out_ready = 1'b0;
    tick();
    in_valid  = 1'b0;
    in_bypass = 1'($urandom_range(0, 1));
    in_state  = garbage();
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, 128'(n), byp ? 128'(0) : 128'(4));
    chk({tag, " result"}, out_state, exp);
    stable = 1'b1;
    moved  = 1'b0;
    for (int k = 0; k < 64 && !moved; k++) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!out_valid || out_state !== exp || in_ready) stable = 1'b0;
      moved = out_ready;
      tick();
    end
    out_ready = 1'b0;
    chk({tag, " held until transfer"}, 128'(stable), 128'(1));
    chk({tag, " out_valid after transfer"}, 128'(out_valid), 128'(0));
    chk({tag, " in_ready after transfer"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    logic [127:0] alt[2];
    logic [127:0] exp_q[$];
    int           acc_t[$];
    int           idx;
    bit           ok;
    logic [127:0] snap;
    logic [127:0] s;
    logic         byp;

    tbl[0] = '{st: 128'h8e4da1bc_d5d5d7d6_4d7ebdf8_01010101, byp: 1'b0,
               exp: 128'hdb135345_d4d4d4d5_2d26314c_01010101};
    tbl[1] = '{st: 128'h8e4da1bc_d5d5d7d6_4d7ebdf8_01010101, byp: 1'b1,
               exp: 128'h8e4da1bc_d5d5d7d6_4d7ebdf8_01010101};
    tbl[2] = '{st: 128'h9fdc589d_9fdc589d_9fdc589d_9fdc589d, byp: 1'b0,
               exp: 128'hf20a225c_f20a225c_f20a225c_f20a225c};
    tbl[3] = '{st: 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6, byp: 1'b0,
               exp: 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6};
    tbl[4] = '{st: 128'h01010101_9fdc589d_4d7ebdf8_8e4da1bc, byp: 1'b0,
               exp: 128'h01010101_f20a225c_2d26314c_db135345};
    tbl[5] = '{st: 128'h0, byp: 1'b0, exp: 128'h0};
    tbl[6] = '{st: 128'hffffffff_ffffffff_ffffffff_ffffffff, byp: 1'b1,
               exp: 128'hffffffff_ffffffff_ffffffff_ffffffff};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_state  = '0;
    in_bypass = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("reset in_ready", 128'(in_ready), 128'(1));
    chk("reset out_valid", 128'(out_valid), 128'(0));
    chk("reset out_state", out_state, 128'h0);
    chk("reset busy", 128'(busy), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Directed table
    for (int i = 0; i < 7; i++) begin
      xfer(tbl[i].st, tbl[i].byp, tbl[i].exp, 1'b0, $sformatf("table[%0d]", i));
    end

    // Backpressure: result held for 10 stalled cycles
    in_valid  = 1'b1;
    in_state  = tbl[0].st;
    in_bypass = 1'b0;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 20 && !out_valid; k++) tick();
    snap = out_state;
    chk("backpressure result", snap, tbl[0].exp);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("backpressure out_valid", 128'(out_valid), 128'(1));
      chk("backpressure out_state", out_state, snap);
      chk("backpressure in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("backpressure release out_valid", 128'(out_valid), 128'(0));
    chk("backpressure release in_ready", 128'(in_ready), 128'(1));

    // Continuous in_valid, fixed-point states, garbage on in_state while busy
    alt[0]    = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;
    alt[1]    = 128'h01010101_01010101_01010101_01010101;
    idx       = 0;
    ok        = 1'b1;
    in_valid  = 1'b1;
    in_bypass = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (in_ready !== !busy) ok = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) chk("continuous spurious output", out_state, 128'hx);
        else chk("continuous output", out_state, exp_q.pop_front());
      end
      if (in_ready) begin
        in_state = alt[idx % 2];
        exp_q.push_back(in_state);
        acc_t.push_back(cyc);
        idx++;
      end else begin
        in_state = garbage();
      end
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
      if (out_valid) chk("continuous drain", out_state, exp_q.pop_front());
      tick();
    end
    chk("continuous in_ready vs busy", 128'(ok), 128'(1));
    chk("continuous acceptance count", 128'(acc_t.size()), 128'(10));
    for (int i = 1; i < acc_t.size(); i++) begin
      chk("continuous acceptance spacing", 128'(acc_t[i] - acc_t[i-1]), 128'(6));
    end
    out_ready = 1'b0;
    tick();

    // Reset two cycles into RUN
    in_valid  = 1'b1;
    in_state  = tbl[0].st;
    in_bypass = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrun reset out_valid", 128'(out_valid), 128'(0));
    chk("midrun reset in_ready", 128'(in_ready), 128'(1));
    chk("midrun reset out_state", out_state, 128'h0);
    chk("midrun reset busy", 128'(busy), 128'(0));
    #2;
    rst = 1'b0;
    xfer(tbl[0].st, 1'b0, tbl[0].exp, 1'b0, "after reset");

    // Randomized against the model
    for (int i = 0; i < 1000; i++) begin
      s   = garbage();
      byp = 1'($urandom_range(0, 1));
      xfer(s, byp, byp ? s : model(s), 1'b1, $sformatf("random[%0d]", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
